// File: rtl/fm_arb_pkg.sv
// Shared definitions for the frame memory arbiter.
//   state_t   : burst sequencer states (IDLE -> CMD -> DATA -> DONE)
//   REQ_WR/RD : requester identifiers used for the round-robin pointer,
//               the winner select and the latched burst direction.
package fm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic REQ_WR = 1'b0;
  localparam logic REQ_RD = 1'b1;

endpackage

// File: rtl/fm_arb_pick.sv
// Combinational winner select between the camera writer and display reader.
// Ports:
//   wr_req, rd_req : pending burst requests
//   rd_urgent      : display FIFO below its low-water mark
//   wr_wait/rd_wait: consecutive lost arbitrations per requester
//   rr_ptr         : side favoured when both request with no override
//   valid          : at least one requester is asking
//   winner         : REQ_WR or REQ_RD (meaningful only when valid)
module fm_arb_pick
  import fm_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int WAIT_W   = 3
) (
  input  logic              wr_req,
  input  logic              rd_req,
  input  logic              rd_urgent,
  input  logic [WAIT_W-1:0] wr_wait,
  input  logic [WAIT_W-1:0] rd_wait,
  input  logic              rr_ptr,
  output logic              valid,
  output logic              winner
);

  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  // NOTE: every output gets a default before any branch, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    valid  = wr_req | rd_req;
    winner = REQ_WR;
    // A starved requester beats even an urgent read.
    if (wr_req && wr_wait == WAIT_MAX) begin
      winner = REQ_WR;
    end else if (rd_req && rd_wait == WAIT_MAX) begin
      winner = REQ_RD;
    end else if (rd_urgent && rd_req) begin
      winner = REQ_RD;
    end else if (wr_req && rd_req) begin
      winner = rr_ptr;
    end else if (rd_req) begin
      winner = REQ_RD;
    end
  end

endmodule

// File: rtl/frame_mem_arbiter.sv
// Shares one burst memory command port between the camera frame writer and
// the display frame reader. One burst is in flight at a time; completion is
// detected by counting data beats against the latched burst length.
// Ports:
//   iCLK, iRST                  : clock, synchronous active-high reset
//   iWR_REQ/ADDR/LEN, oWR_GNT   : writer request, burst fields, grant pulse
//   oWR_DONE                    : pulse after the last write beat
//   iRD_REQ/ADDR/LEN/URGENT     : reader request, burst fields, urgency
//   oRD_GNT, oRD_DONE           : reader grant / completion pulses
//   oMEM_CMD_VALID/iMEM_CMD_READY, oMEM_CMD_WR, oMEM_ADDR, oMEM_LEN
//                               : command to the memory bridge
//   iMEM_BEAT                   : one data beat transferred
//   oBUSY                       : sequencer not idle
//   oERR                        : sticky, a beat arrived outside DATA
module frame_mem_arbiter
  import fm_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int LEN_W    = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iWR_REQ,
  input  logic [ADDR_W-1:0] iWR_ADDR,
  input  logic [LEN_W-1:0]  iWR_LEN,
  output logic              oWR_GNT,
  output logic              oWR_DONE,
  input  logic              iRD_REQ,
  input  logic [ADDR_W-1:0] iRD_ADDR,
  input  logic [LEN_W-1:0]  iRD_LEN,
  input  logic              iRD_URGENT,
  output logic              oRD_GNT,
  output logic              oRD_DONE,
  output logic              oMEM_CMD_VALID,
  input  logic              iMEM_CMD_READY,
  output logic              oMEM_CMD_WR,
  output logic [ADDR_W-1:0] oMEM_ADDR,
  output logic [LEN_W-1:0]  oMEM_LEN,
  input  logic              iMEM_BEAT,
  output logic              oBUSY,
  output logic              oERR
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  state_t              state_q, state_d;
  logic                cmd_wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    beat_cnt_q;
  logic [WAIT_W-1:0]   wr_wait_q, rd_wait_q;
  logic                rr_ptr_q;
  logic                wr_gnt_q, rd_gnt_q;
  logic                err_q;
  logic                pick_valid, pick_winner;
  logic                grant;

  fm_arb_pick #(
    .MAX_WAIT (MAX_WAIT),
    .WAIT_W   (WAIT_W)
  ) u_pick (
    .wr_req    (iWR_REQ),
    .rd_req    (iRD_REQ),
    .rd_urgent (iRD_URGENT),
    .wr_wait   (wr_wait_q),
    .rd_wait   (rd_wait_q),
    .rr_ptr    (rr_ptr_q),
    .valid     (pick_valid),
    .winner    (pick_winner)
  );

  // Requests only matter while idle; anything raised mid-burst waits.
  assign grant = (state_q == IDLE) && pick_valid;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_valid) state_d = CMD;
      CMD:     if (iMEM_CMD_READY) state_d = DATA;
      DATA:    if (iMEM_BEAT && beat_cnt_q == len_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all state below updates with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q    <= IDLE;
      cmd_wr_q   <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
      wr_wait_q  <= '0;
      rd_wait_q  <= '0;
      rr_ptr_q   <= REQ_WR;
      wr_gnt_q   <= 1'b0;
      rd_gnt_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_gnt_q <= 1'b0;
      rd_gnt_q <= 1'b0;

      if (grant) begin
        cmd_wr_q   <= (pick_winner == REQ_WR);
        addr_q     <= (pick_winner == REQ_WR) ? iWR_ADDR : iRD_ADDR;
        len_q      <= (pick_winner == REQ_WR) ? iWR_LEN  : iRD_LEN;
        beat_cnt_q <= '0;
        wr_gnt_q   <= (pick_winner == REQ_WR);
        rd_gnt_q   <= (pick_winner == REQ_RD);
        rr_ptr_q   <= ~pick_winner;
        // Winner restarts its wait; the loser ages only if it was asking.
        if (pick_winner == REQ_WR) begin
          wr_wait_q <= '0;
          if (!iRD_REQ)                  rd_wait_q <= '0;
          else if (rd_wait_q != WAIT_MAX) rd_wait_q <= rd_wait_q + 1'b1;
        end else begin
          rd_wait_q <= '0;
          if (!iWR_REQ)                  wr_wait_q <= '0;
          else if (wr_wait_q != WAIT_MAX) wr_wait_q <= wr_wait_q + 1'b1;
        end
      end

      if (state_q == DATA && iMEM_BEAT) beat_cnt_q <= beat_cnt_q + 1'b1;
      if (state_q != DATA && iMEM_BEAT) err_q <= 1'b1;
    end
  end

  assign oWR_GNT        = wr_gnt_q;
  assign oRD_GNT        = rd_gnt_q;
  assign oMEM_CMD_VALID = (state_q == CMD);
  assign oMEM_CMD_WR    = cmd_wr_q;
  assign oMEM_ADDR      = addr_q;
  assign oMEM_LEN       = len_q;
  assign oWR_DONE       = (state_q == DONE) && cmd_wr_q;
  assign oRD_DONE       = (state_q == DONE) && !cmd_wr_q;
  assign oBUSY          = (state_q != IDLE);
  assign oERR           = err_q;

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Self-checking bench for frame_mem_arbiter: arbitration table, a command
// scoreboard fed at request time and drained on command acceptance, and
// hand-written sequences for stall, mid-burst reset and stray-beat error.
module tb_frame_mem_arbiter;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic        iWR_REQ = 1'b0, iRD_REQ = 1'b0, iRD_URGENT = 1'b0;
  logic [31:0] iWR_ADDR = '0, iRD_ADDR = '0;
  logic [7:0]  iWR_LEN = '0, iRD_LEN = '0;
  logic        iMEM_CMD_READY = 1'b0, iMEM_BEAT = 1'b0;
  logic        oWR_GNT, oWR_DONE, oRD_GNT, oRD_DONE;
  logic        oMEM_CMD_VALID, oMEM_CMD_WR, oBUSY, oERR;
  logic [31:0] oMEM_ADDR;
  logic [7:0]  oMEM_LEN;

  frame_mem_arbiter #(.ADDR_W(32), .LEN_W(8), .MAX_WAIT(4)) dut (
    .iCLK(iCLK), .iRST(iRST),
    .iWR_REQ(iWR_REQ), .iWR_ADDR(iWR_ADDR), .iWR_LEN(iWR_LEN),
    .oWR_GNT(oWR_GNT), .oWR_DONE(oWR_DONE),
    .iRD_REQ(iRD_REQ), .iRD_ADDR(iRD_ADDR), .iRD_LEN(iRD_LEN),
    .iRD_URGENT(iRD_URGENT), .oRD_GNT(oRD_GNT), .oRD_DONE(oRD_DONE),
    .oMEM_CMD_VALID(oMEM_CMD_VALID), .iMEM_CMD_READY(iMEM_CMD_READY),
    .oMEM_CMD_WR(oMEM_CMD_WR), .oMEM_ADDR(oMEM_ADDR), .oMEM_LEN(oMEM_LEN),
    .iMEM_BEAT(iMEM_BEAT), .oBUSY(oBUSY), .oERR(oERR)
  );

  always #5 iCLK = ~iCLK;

  int unsigned cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int accepts = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [7:0]  len;
  } cmd_t;
  cmd_t sb_q[$];

  typedef struct {
    logic rst;
    logic wreq;
    logic rreq;
    logic urg;
    logic exp_wr;
  } vec_t;
  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Command scoreboard: every accepted command must match the oldest expectation.
  always @(negedge iCLK) begin
    cmd_t e;
    if (!iRST && oMEM_CMD_VALID && iMEM_CMD_READY) begin
      accepts++;
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected_cmd: got addr %0h expected no command", oMEM_ADDR);
      end else begin
        e = sb_q.pop_front();
        check("sb_wr", oMEM_CMD_WR, e.wr);
        check("sb_addr", oMEM_ADDR, e.addr);
        check("sb_len", oMEM_LEN, e.len);
      end
    end
  end

  task automatic do_reset();
    @(posedge iCLK); #1;
    iRST = 1'b1;
    iWR_REQ = 1'b0; iRD_REQ = 1'b0; iRD_URGENT = 1'b0;
    iMEM_CMD_READY = 1'b0; iMEM_BEAT = 1'b0;
    sb_q.delete();
    @(posedge iCLK); #1;
    iRST = 1'b0;
  endtask

  // One complete burst: request in cycle N, grant in N+1, READY held low for
  // d command cycles, len+1 beats back to back, DONE at N+d+3+len.
  task automatic serve(input logic wreq, input logic rreq, input logic urg,
                       input logic exp_wr, input logic [31:0] wa, input logic [31:0] ra,
                       input logic [7:0] wl, input logic [7:0] rl, input int d);
    logic [31:0] ea;
    logic [7:0]  el;
    int unsigned c0;
    int          acc0;
    cmd_t        e;
    ea = exp_wr ? wa : ra;
    el = exp_wr ? wl : rl;
    @(posedge iCLK); #1;
    iWR_REQ = wreq; iRD_REQ = rreq; iRD_URGENT = urg;
    iWR_ADDR = wa; iRD_ADDR = ra; iWR_LEN = wl; iRD_LEN = rl;
    c0   = cyc;
    acc0 = accepts;
    e.wr = exp_wr; e.addr = ea; e.len = el;
    sb_q.push_back(e);
    @(negedge iCLK);
    check("gnt_early", {oWR_GNT, oRD_GNT, oBUSY}, 3'b000);
    @(negedge iCLK);
    check("gnt_wr", oWR_GNT, exp_wr);
    check("gnt_rd", oRD_GNT, !exp_wr);
    check("cmd_valid", oMEM_CMD_VALID, 1'b1);
    check("cmd_wr", oMEM_CMD_WR, exp_wr);
    check("cmd_addr", oMEM_ADDR, ea);
    check("cmd_len", oMEM_LEN, el);
    iWR_REQ = 1'b0; iRD_REQ = 1'b0; iRD_URGENT = 1'b0;
    iMEM_CMD_READY = (d == 0);
    for (int i = 1; i < d; i++) begin
      @(negedge iCLK);
      check("hold_valid", oMEM_CMD_VALID, 1'b1);
      check("hold_addr", oMEM_ADDR, ea);
      check("hold_len", oMEM_LEN, el);
      check("hold_no_gnt", {oWR_GNT, oRD_GNT}, 2'b00);
    end
    if (d > 0) begin
      @(posedge iCLK); #1;
      iMEM_CMD_READY = 1'b1;
    end
    @(posedge iCLK); #1;
    iMEM_CMD_READY = 1'b0;
    check("accept_once", accepts - acc0, 1);
    iMEM_BEAT = 1'b1;
    repeat (int'(el) + 1) @(posedge iCLK);
    #1;
    iMEM_BEAT = 1'b0;
    @(negedge iCLK);
    check("done_wr", oWR_DONE, exp_wr);
    check("done_rd", oRD_DONE, !exp_wr);
    check("done_cycle", cyc - c0, d + 3 + int'(el));
    @(negedge iCLK);
    check("idle_after", {oBUSY, oWR_DONE, oRD_DONE, oMEM_CMD_VALID}, 4'b0000);
    check("accept_total", accepts - acc0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // {rst, wreq, rreq, urg, exp_wr}
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};  // rr starts at WR
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};  // urgent read wins 4 times
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};  // starved writer forced in
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};  // urgent read resumes
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};  // single requesters
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};  // urgent without read req
    vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};  // rr moved to RD by row 12

    do_reset();
    @(negedge iCLK);
    check("reset_ctrl", {oWR_GNT, oRD_GNT, oWR_DONE, oRD_DONE, oMEM_CMD_VALID,
                         oMEM_CMD_WR, oBUSY, oERR}, 8'h00);
    check("reset_addr", oMEM_ADDR, 32'h0);
    check("reset_len", oMEM_LEN, 8'h0);

    // Basic write burst, then a single-beat read for minimum latency.
    serve(1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'h0, 8'd3, 8'd0, 0);
    serve(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h2000, 8'd0, 8'd0, 0);

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].rst) do_reset();
      serve(vecs[i].wreq, vecs[i].rreq, vecs[i].urg, vecs[i].exp_wr,
            32'h1000 + 32'(i) * 32'h40, 32'h8000 + 32'(i) * 32'h40,
            8'(i % 4), 8'((i + 1) % 4), 0);
    end

    // Command stalled for 10 cycles.
    serve(1'b1, 1'b0, 1'b0, 1'b1, 32'hABC0, 32'h0, 8'd5, 8'd0, 10);
    check("no_err_normal", oERR, 1'b0);

    // Reset in the middle of an 8-beat write after 2 beats.
    do_reset();
    @(posedge iCLK); #1;
    iWR_REQ = 1'b1; iWR_ADDR = 32'h4000; iWR_LEN = 8'd7;
    sb_q.push_back('{1'b1, 32'h4000, 8'd7});
    @(negedge iCLK);
    @(negedge iCLK);
    check("mid_gnt", oWR_GNT, 1'b1);
    iWR_REQ = 1'b0;
    iMEM_CMD_READY = 1'b1;
    @(posedge iCLK); #1;
    iMEM_CMD_READY = 1'b0;
    iMEM_BEAT = 1'b1;
    repeat (2) @(posedge iCLK);
    #1;
    iMEM_BEAT = 1'b0;
    iRST = 1'b1;
    @(posedge iCLK); #1;
    iRST = 1'b0;
    @(negedge iCLK);
    check("mid_rst_ctrl", {oWR_GNT, oRD_GNT, oWR_DONE, oRD_DONE, oMEM_CMD_VALID,
                           oMEM_CMD_WR, oBUSY, oERR}, 8'h00);
    check("mid_rst_addr", oMEM_ADDR, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge iCLK);
      check("mid_rst_quiet", {oWR_DONE, oRD_DONE, oBUSY}, 3'b000);
    end
    serve(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h5000, 8'd0, 8'd2, 0);

    // Stray beat while idle: sticky error, no completion.
    @(posedge iCLK); #1;
    iMEM_BEAT = 1'b1;
    @(posedge iCLK); #1;
    iMEM_BEAT = 1'b0;
    @(negedge iCLK);
    check("err_set", oERR, 1'b1);
    check("err_no_done", {oWR_DONE, oRD_DONE, oBUSY}, 3'b000);
    repeat (3) @(negedge iCLK);
    check("err_sticky", oERR, 1'b1);
    serve(1'b1, 1'b0, 1'b0, 1'b1, 32'h6000, 32'h0, 8'd1, 8'd0, 0);
    check("err_after_burst", oERR, 1'b1);
    do_reset();
    @(negedge iCLK);
    check("err_cleared", oERR, 1'b0);
    check("sb_drained", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
